// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if : start/done handshake and result bundle for bin2bcd_seq.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [15:0]      bcd_out;
  logic             ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq : sequential double-dabble, 14-bit binary -> 4 packed BCD digits.
// Rev 1.0 -- define BIN2BCD_SAT_EN to saturate overflowing results at 9999.
// ---------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq #(
  parameter int BIN_W = 14,
  parameter int ITER  = 14
) (
  input  wire logic      clk,
  input  wire logic      rst,
  bin2bcd_seq_if.slave   bus
);

  localparam int               c_CNT_W = $clog2(ITER);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(ITER - 1);
  localparam logic [BIN_W-1:0] c_MAX   = BIN_W'(9999);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [BIN_W-1:0]   r_bin, w_bin_next;
  logic [15:0]        r_scratch, w_scratch_next;
  logic [15:0]        w_adj;
  logic [15:0]        w_result;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
  logic               r_ovf_pend, w_ovf_pend_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               r_ovf, w_ovf_next;
  logic [15:0]        r_bcd, w_bcd_next;

  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                             r_scratch[4*i +: 4] + 4'd3 : r_scratch[4*i +: 4];
  end

`ifdef BIN2BCD_SAT_EN
  assign w_result = r_ovf_pend ? 16'h9999 : r_scratch;
`else
  assign w_result = r_scratch;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_bin_next      = r_bin;
    w_scratch_next  = r_scratch;
    w_cnt_next      = r_cnt;
    w_ovf_pend_next = r_ovf_pend;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_ovf_next      = r_ovf;
    w_bcd_next      = r_bcd;
    case (r_state)
      S_IDLE: begin
        w_busy_next = 1'b0;
        if (bus.start) begin
          w_state_next    = S_SHIFT;
          w_bin_next      = bus.bin_in;
          w_scratch_next  = 16'h0000;
          w_cnt_next      = '0;
          w_ovf_pend_next = (bus.bin_in > c_MAX);
          w_busy_next     = 1'b1;
        end
      end
      S_SHIFT: begin
        // Bit leaving the thousands nibble falls off: raw result is mod 10000.
        {w_scratch_next, w_bin_next} = {w_adj, r_bin} << 1;
        w_cnt_next = r_cnt + c_CNT_W'(1);
        if (r_cnt == c_LAST) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_bcd_next   = w_result;
        w_ovf_next   = r_ovf_pend;
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_scratch  <= 16'h0000;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd      <= 16'h0000;
    end else begin
      r_state    <= w_state_next;
      r_bin      <= w_bin_next;
      r_scratch  <= w_scratch_next;
      r_cnt      <= w_cnt_next;
      r_ovf_pend <= w_ovf_pend_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_ovf      <= w_ovf_next;
      r_bcd      <= w_bcd_next;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_out = r_bcd;
  assign bus.ovf     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq : directed scoreboard bench for bin2bcd_seq.
// Rev 1.0 -- expectations follow BIN2BCD_SAT_EN when it is defined.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(14)) bus ();

  bin2bcd_seq #(.BIN_W(14), .ITER(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [16:0] exp_q[$];
  logic [15:0] last_bcd    = 16'h0000;

  // Expected {ovf, bcd} from plain decimal arithmetic.
  function automatic logic [16:0] model(input int v);
    int r;
    r = v % 10000;
`ifdef BIN2BCD_SAT_EN
    if (v > 9999) r = 9999;
`endif
    return {(v > 9999), 4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request; the following tick() is the accepting edge.
  task automatic drive(input int v);
    bus.start  = 1'b1;
    bus.bin_in = 14'(v);
    exp_q.push_back(model(v));
  endtask

  // Entered just after the accepting edge plus 'pre' further cycles.
  task automatic wait_done(input string tag, input int pre);
    int n;
    int busy_cnt;
    logic stable;
    logic [16:0] e;
    n        = pre;
    busy_cnt = pre + ((bus.busy === 1'b1) ? 1 : 0);
    stable   = 1'b1;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done !== 1'b1 && bus.bcd_out !== last_bcd) stable = 1'b0;
    end
    chk({tag, " latency"}, n, 15);
    chk({tag, " busy_cycles"}, busy_cnt, 15);
    chk({tag, " hold"}, {31'd0, stable}, 32'd1);
    chk({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " bcd_out"}, {16'd0, bus.bcd_out}, {16'd0, e[15:0]});
      chk({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, e[16]});
      last_bcd = e[15:0];
    end
  endtask

  task automatic convert(input string tag, input int v);
    drive(v);
    tick();
    bus.start  = 1'b0;
    bus.bin_in = 14'($urandom_range(0, 16383));
    wait_done(tag, 0);
    tick();
    chk({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    chk({tag, " no_done"}, pulses, 0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (2) tick();
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset bcd", {16'd0, bus.bcd_out}, 32'd0);
    chk("reset ovf", {31'd0, bus.ovf}, 32'd0);
    rst = 1'b0;
    tick();

    convert("c1234", 1234);
    convert("c0", 0);
    convert("c9999", 9999);
    convert("c10", 10);
    convert("c12345", 12345);
    convert("c16383", 16383);
    for (int k = 0; k < 3; k++) convert("crand", int'($urandom_range(0, 16383)));

    // Start pulse mid-conversion must be dropped.
    drive(4321);
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start  = 1'b1;
    bus.bin_in = 14'd1111;
    tick();
    bus.start = 1'b0;
    wait_done("ign", 5);
    quiet("ign", 20);
    chk("ign queue", exp_q.size(), 0);

    // Start held high: second request taken on the cycle after done.
    drive(42);
    tick();
    bus.bin_in = 14'd987;
    exp_q.push_back(model(987));
    wait_done("b2b_a", 0);
    tick();
    chk("b2b accept busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b accept done", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    wait_done("b2b_b", 0);
    tick();

    // Reset mid-conversion discards the partial result.
    bus.start  = 1'b1;
    bus.bin_in = 14'd5678;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("rstmid busy", {31'd0, bus.busy}, 32'd0);
    chk("rstmid done", {31'd0, bus.done}, 32'd0);
    chk("rstmid bcd", {16'd0, bus.bcd_out}, 32'd0);
    tick();
    rst = 1'b0;
    last_bcd = 16'h0000;
    quiet("rstmid", 20);
    convert("c5678", 5678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
